// File: rtl/exu_div_issue_ctl.sv
// Divide issue controller: launches one op to the fixed-latency divider, returns
// its result to writeback, and polices the latency contract.
module exu_div_issue_ctl #(
  parameter int unsigned LATENCY = 34,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_dividend,
  input  logic [31:0]      req_divisor,
  input  logic             req_unsign,
  input  logic             req_rem,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush_lower,
  output logic             div_valid,
  output logic             div_unsign,
  output logic             div_rem,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  output logic             div_flush,
  input  logic             div_stall,
  input  logic             div_finish,
  input  logic [31:0]      div_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy,
  output logic             lat_err
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout;

  // Timeout fires in the WAIT cycle whose count hits TIMEOUT with no finish.
  assign timeout   = (state == WAIT) && (cnt >= TMO_C) && !div_finish;

  // Abort must reach the divider in the same cycle as the flush or timeout.
  assign div_flush = (((state == LAUNCH) || (state == WAIT)) && flush_lower) ||
                     (timeout && !flush_lower);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      div_valid    <= 1'b0;
      div_unsign   <= 1'b0;
      div_rem      <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_tag       <= '0;
      lat_err      <= 1'b0;
    end else begin
      div_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid && !flush_lower) begin
            div_dividend <= req_dividend;
            div_divisor  <= req_divisor;
            div_unsign   <= req_unsign;
            div_rem      <= req_rem;
            wb_tag       <= req_tag;
            div_valid    <= 1'b1;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (flush_lower) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt   <= CNT_W'(1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush_lower) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (div_finish) begin
            wb_data  <= div_result;
            wb_valid <= 1'b1;
            state    <= WB;
            if (cnt != LAT_C) lat_err <= 1'b1;
          end else if (timeout) begin
            lat_err   <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            // A divider that is not stalling before its finish has broken timing.
            if (!div_stall) lat_err <= 1'b1;
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
        end
        WB: begin
          if (wb_ready || flush_lower) begin
            wb_valid  <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_div_issue_ctl.sv
// Directed bench for exu_div_issue_ctl: transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_exu_div_issue_ctl;
  localparam int unsigned LATENCY = 34;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned TAG_W   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [31:0]      req_dividend, req_divisor;
  logic             req_unsign, req_rem;
  logic [TAG_W-1:0] req_tag;
  logic             flush_lower;
  logic             div_valid, div_unsign, div_rem, div_flush;
  logic [31:0]      div_dividend, div_divisor;
  logic             div_stall, div_finish;
  logic [31:0]      div_result;
  logic             wb_valid, wb_ready;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             busy, lat_err;

  exu_div_issue_ctl #(.LATENCY(LATENCY), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_unsign(req_unsign), .req_rem(req_rem), .req_tag(req_tag),
    .flush_lower(flush_lower),
    .div_valid(div_valid), .div_unsign(div_unsign), .div_rem(div_rem),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_flush(div_flush),
    .div_stall(div_stall), .div_finish(div_finish), .div_result(div_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
    .busy(busy), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int dv_pulses = 0;
  int fl_pulses = 0;
  int wb_seen   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one op in flight tracked by its age since launch, or one result held.
  bit               op_live, res_live, m_lat;
  int               age;
  logic [31:0]      m_dvd, m_dvs, m_wb;
  logic             m_uns, m_rem;
  logic [TAG_W-1:0] m_tag;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      op_live <= 0; res_live <= 0; m_lat <= 0; age <= 0;
      m_dvd <= '0; m_dvs <= '0; m_wb <= '0; m_uns <= 0; m_rem <= 0; m_tag <= '0;
    end else if (op_live) begin
      if (flush_lower) op_live <= 0;
      else if (age > 0 && div_finish) begin
        op_live <= 0; res_live <= 1; m_wb <= div_result;
        if (age != LATENCY) m_lat <= 1;
      end else if (age > 0 && age >= TIMEOUT) begin
        op_live <= 0; m_lat <= 1;
      end else begin
        if (age > 0 && !div_stall) m_lat <= 1;
        age <= age + 1;
      end
    end else if (res_live) begin
      if (wb_ready || flush_lower) res_live <= 0;
    end else if (req_valid && !flush_lower) begin
      op_live <= 1; age <= 0;
      m_dvd <= req_dividend; m_dvs <= req_divisor;
      m_uns <= req_unsign; m_rem <= req_rem; m_tag <= req_tag;
    end
  end

  logic exp_flush;
  always @(negedge clk) begin
    if (!rst) begin
      exp_flush = op_live && (flush_lower || (age > 0 && age >= TIMEOUT && !div_finish));
      chk("req_ready",    req_ready,    !op_live && !res_live);
      chk("busy",         busy,         op_live || res_live);
      chk("div_valid",    div_valid,    op_live && age == 0);
      chk("div_flush",    div_flush,    exp_flush);
      chk("div_dividend", div_dividend, m_dvd);
      chk("div_divisor",  div_divisor,  m_dvs);
      chk("div_unsign",   div_unsign,   m_uns);
      chk("div_rem",      div_rem,      m_rem);
      chk("wb_valid",     wb_valid,     res_live);
      chk("wb_data",      wb_data,      m_wb);
      chk("wb_tag",       wb_tag,       m_tag);
      chk("lat_err",      lat_err,      m_lat);
      dv_pulses += int'(div_valid);
      fl_pulses += int'(div_flush);
      wb_seen   += int'(wb_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic u,
                       input logic r, input logic [TAG_W-1:0] t);
    int n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (!req_ready) chk("issue_ready_timeout", req_ready, 1);
    req_valid = 1; req_dividend = a; req_divisor = b;
    req_unsign = u; req_rem = r; req_tag = t;
    tick();
    req_valid = 0;
  endtask

  // Called in the launch cycle; raises finish in cycle n after it.
  task automatic finish_at(input int n, input logic [31:0] res);
    repeat (n) tick();
    div_finish = 1; div_result = res;
    tick();
    div_finish = 0;
  endtask

  task automatic wb_accept(input int k);
    wb_ready = 0;
    repeat (k) tick();
    wb_ready = 1;
    tick();
    wb_ready = 0;
  endtask

  task automatic reset_pulse();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  int base_dv, base_fl, base_wb;

  initial begin
    rst = 1; req_valid = 0; req_dividend = '0; req_divisor = '0;
    req_unsign = 0; req_rem = 0; req_tag = '0; flush_lower = 0;
    div_stall = 1; div_finish = 0; div_result = '0; wb_ready = 0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy",      busy,      0);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_wb_valid",  wb_valid,  0);
    chk("rst_lat_err",   lat_err,   0);
    chk("rst_div_flush", div_flush, 0);
    rst = 0;
    tick();

    // Nominal 100/7 signed quotient
    base_dv = dv_pulses;
    issue(32'd100, 32'd7, 0, 0, 5'd3);
    chk("nom_dividend", div_dividend, 32'd100);
    chk("nom_divisor",  div_divisor,  32'd7);
    finish_at(34, 32'd14);
    chk("nom_wb_valid", wb_valid, 1);
    chk("nom_wb_data",  wb_data,  32'd14);
    chk("nom_wb_tag",   wb_tag,   5'd3);
    chk("nom_lat_err",  lat_err,  0);
    wb_accept(0);
    chk("nom_dv_pulses", 64'(dv_pulses - base_dv), 1);

    // Writeback backpressure for 5 cycles
    issue(32'd500, 32'd5, 0, 0, 5'd9);
    finish_at(34, 32'h1234);
    wb_ready = 0;
    repeat (5) tick();
    chk("bp_wb_valid",  wb_valid,  1);
    chk("bp_wb_data",   wb_data,   32'h1234);
    chk("bp_req_ready", req_ready, 0);
    wb_ready = 1; tick(); wb_ready = 0;
    chk("bp_req_ready_after", req_ready, 1);

    // Unsigned remainder attributes
    issue(32'hFFFF_FFF0, 32'd3, 1, 1, 5'd31);
    chk("ur_unsign",   div_unsign,   1);
    chk("ur_rem",      div_rem,      1);
    chk("ur_dividend", div_dividend, 32'hFFFF_FFF0);
    finish_at(34, 32'd0);
    chk("ur_wb_tag", wb_tag, 5'd31);
    wb_accept(1);

    // Early finish sets sticky lat_err but still delivers
    issue(32'd9, 32'd2, 0, 0, 5'd1);
    finish_at(20, 32'h55);
    chk("early_wb_data", wb_data, 32'h55);
    chk("early_lat_err", lat_err, 1);
    wb_accept(0);
    issue(32'd8, 32'd2, 0, 0, 5'd2);
    finish_at(34, 32'd4);
    wb_accept(0);
    chk("early_sticky", lat_err, 1);

    reset_pulse();
    chk("clr_lat_err", lat_err, 0);

    // Timeout, then a stray late finish
    base_fl = fl_pulses; base_wb = wb_seen;
    issue(32'd1, 32'd1, 0, 0, 5'd4);
    repeat (63) tick();
    chk("tmo_flush", div_flush, 1);
    tick();
    chk("tmo_flush_off", div_flush, 0);
    chk("tmo_lat_err",   lat_err,   1);
    tick();
    div_finish = 1; div_result = 32'hDEAD;
    tick();
    div_finish = 0;
    tick();
    chk("tmo_fl_pulses", 64'(fl_pulses - base_fl), 1);
    chk("tmo_no_wb",     64'(wb_seen - base_wb),   0);
    chk("tmo_req_ready", req_ready, 1);

    reset_pulse();

    // Flush coincident with an on-time finish
    base_wb = wb_seen;
    issue(32'd40, 32'd4, 0, 0, 5'd6);
    repeat (34) tick();
    flush_lower = 1; div_finish = 1; div_result = 32'd10;
    #1 chk("fw_div_flush", div_flush, 1);
    tick();
    flush_lower = 0; div_finish = 0;
    chk("fw_wb_valid",  wb_valid,  0);
    chk("fw_req_ready", req_ready, 1);
    chk("fw_lat_err",   lat_err,   0);
    tick();
    chk("fw_no_wb", 64'(wb_seen - base_wb), 0);

    // Flush in the launch cycle
    issue(32'd40, 32'd4, 0, 0, 5'd7);
    flush_lower = 1;
    #1 chk("fl_div_flush", div_flush, 1);
    tick();
    flush_lower = 0;
    chk("fl_req_ready", req_ready, 1);
    chk("fl_busy",      busy,      0);

    // Flush during writeback drops the result
    issue(32'd40, 32'd4, 0, 0, 5'd8);
    finish_at(34, 32'd77);
    flush_lower = 1; wb_ready = 0;
    tick();
    flush_lower = 0;
    chk("fwb_wb_valid",  wb_valid,  0);
    chk("fwb_req_ready", req_ready, 1);

    // Divider dropping stall before finish
    issue(32'd12, 32'd3, 0, 0, 5'd10);
    repeat (10) tick();
    div_stall = 0; tick(); div_stall = 1;
    finish_at(23, 32'd4);
    chk("stall_lat_err", lat_err, 1);
    wb_accept(0);

    // Async reset between clock edges in the middle of WAIT
    issue(32'd77, 32'd7, 0, 0, 5'd11);
    repeat (10) tick();
    #2 rst = 1;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_busy",      busy,      0);
    chk("arst_lat_err",   lat_err,   0);
    chk("arst_dividend",  div_dividend, 0);
    chk("arst_wb_tag",    wb_tag,    0);
    tick(); tick();
    rst = 0;

    // Recovery after reset
    issue(32'd21, 32'd7, 0, 0, 5'd12);
    finish_at(34, 32'd3);
    chk("rec_wb_data", wb_data, 32'd3);
    chk("rec_lat_err", lat_err, 0);
    wb_accept(2);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/exu_div_issue_ctl.md
Name: exu_div_issue_ctl

Overview:
- Initiator side of the constant-latency divide interface: accepts a divide op from decode, launches it to the divider with a one-cycle valid pulse, waits for finish, captures the result and hands it to writeback with a valid/ready handshake.
- Also enforces the fixed-latency contract (MBPTA timing determinism) with a cycle counter, a sticky latency-error flag and a timeout abort.
- Sits in the EXU between the decode divide issue path and the divider datapath.

Parameters:
LATENCY, 34, required cycles from the div_valid cycle to the div_finish cycle
TIMEOUT, 63, count at which a missing finish aborts the op; must exceed LATENCY, max 63
TAG_W, 5, width of the destination tag carried with the op

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  decode presents a divide op
req_ready  out  1  block can accept an op
req_dividend  in  32  numerator
req_divisor  in  32  denominator
req_unsign  in  1  unsigned divide
req_rem  in  1  return remainder instead of quotient
req_tag  in  TAG_W  destination tag
flush_lower  in  1  pipeline flush
div_valid  out  1  one-cycle launch pulse to divider
div_unsign  out  1  registered op attribute
div_rem  out  1  registered op attribute
div_dividend  out  32  registered numerator
div_divisor  out  32  registered denominator
div_flush  out  1  abort to divider
div_stall  in  1  divider busy
div_finish  in  1  divider result valid this cycle
div_result  in  32  divider result
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts result
wb_data  out  32  captured result
wb_tag  out  TAG_W  tag of result
busy  out  1  state != IDLE
lat_err  out  1  sticky latency-contract violation

Behaviour:
- Reset (async, any time, incl. mid-op): state IDLE, counter 0. All outputs 0 except req_ready=1. Operand/tag/result registers 0.
- States: IDLE, LAUNCH, WAIT, WB.
- IDLE: req_ready=1. req_valid & ~flush_lower -> capture operands, attributes, tag; go LAUNCH. req_valid & flush_lower -> op dropped, stay IDLE.
- LAUNCH (exactly 1 cycle): div_valid=1; counter<=1; go WAIT. flush_lower -> div_flush=1, no launch counted, go IDLE.
- WAIT: counter increments by 1 per cycle, saturating at 63.
  - div_finish: capture div_result into wb_data; go WB. If counter != LATENCY, set lat_err (result still delivered).
  - counter reaches TIMEOUT without finish: set lat_err, div_flush=1 for 1 cycle, go IDLE, no writeback.
  - Cycle count: the launch cycle is cycle 0. Finish is legal only in cycle LATENCY, i.e. counter==LATENCY in the finish cycle.
- WB: wb_valid=1, holding wb_data and wb_tag stable until wb_ready. wb_valid & wb_ready -> IDLE. req_ready is 0 in WB; no back-to-back accept in the same cycle.
- Flush:
  - flush_lower in WAIT -> div_flush=1 (combinational, same cycle), go IDLE, no capture. Flush beats a simultaneous div_finish.
  - flush_lower in WB -> wb_valid drops next cycle, go IDLE. A simultaneous wb_ready still completes the handshake that cycle, so the result counts as delivered.
- div_finish outside WAIT is ignored (stray or late after timeout) and does not set lat_err.
- div_stall is observed only for lat_err: stall low in WAIT before finish sets lat_err.
- lat_err is cleared only by rst.
- busy = (state != IDLE).
- Throughput: at most one op per LATENCY+3 cycles.

Test Plan:
- Nominal: req 100/7 signed quotient, tag 3; divider finishes 34 cycles after div_valid with 14 -> wb_valid, wb_data=14, wb_tag=3, lat_err=0, one div_valid pulse.
- Writeback backpressure: wb_ready low 5 cycles -> wb_valid held, wb_data stable, req_ready=0; accept on cycle 6 -> IDLE, req_ready=1 next cycle.
- Early finish at counter 20 with result 0x55 -> wb_data=0x55 delivered, lat_err=1 and stays 1 across later correct ops.
- Timeout: no finish -> at counter 63 div_flush pulses 1 cycle, lat_err=1, no wb_valid; stray finish 2 cycles later ignored.
- Flush at WAIT cycle 34 coincident with finish -> div_flush=1, no wb_valid, IDLE next cycle; flush during LAUNCH -> div_flush=1, IDLE.
- Async rst asserted mid-WAIT between clock edges -> outputs cleared immediately, req_ready=1, lat_err=0.
